// File: rtl/bp_be_fe_feedback_if.sv
// bp_be_fe_feedback_if: resolve / exception / redirect / attaboy bundle between the BE
// feedback block and its neighbours. The slave modport is the feedback block's view.
// Configuration selector shared by the interface and the feedback block.
typedef enum logic [0:0] {
  e_bp_default_cfg = 1'b0,
  e_bp_small_cfg   = 1'b1
} bp_params_e;

interface bp_be_fe_feedback_if #(
  parameter bp_params_e bp_params_p = e_bp_default_cfg
);
  localparam int unsigned vaddr_width_p = (bp_params_p == e_bp_default_cfg) ? 39 : 32;
  localparam int unsigned branch_metadata_fwd_width_p =
      (bp_params_p == e_bp_default_cfg) ? 36 : 16;

  // Resolved-instruction handshake from the BE
  logic                                   resolve_v_i;
  logic                                   resolve_ready_o;
  logic [vaddr_width_p-1:0]               resolve_pc_i;
  logic [vaddr_width_p-1:0]               resolve_npc_pred_i;
  logic [vaddr_width_p-1:0]               resolve_tgt_i;
  logic                                   resolve_br_i;
  logic                                   resolve_taken_i;
  logic [branch_metadata_fwd_width_p-1:0] resolve_br_metadata_fwd_i;

  // Exception / trap redirect request
  logic                                   exc_v_i;
  logic [vaddr_width_p-1:0]               exc_pc_i;

  // Redirect to the FE PC generator
  logic                                   redirect_v_o;
  logic [vaddr_width_p-1:0]               redirect_pc_o;
  logic                                   redirect_br_v_o;
  logic [branch_metadata_fwd_width_p-1:0] redirect_br_metadata_fwd_o;
  logic                                   redirect_br_taken_o;
  logic                                   redirect_br_ntaken_o;
  logic                                   redirect_br_nonbr_o;

  // Correct-prediction training messages
  logic                                   attaboy_v_o;
  logic [vaddr_width_p-1:0]               attaboy_pc_o;
  logic [branch_metadata_fwd_width_p-1:0] attaboy_br_metadata_fwd_o;
  logic                                   attaboy_taken_o;
  logic                                   attaboy_ntaken_o;
  logic                                   attaboy_yumi_i;

  modport slave (
    input  resolve_v_i, resolve_pc_i, resolve_npc_pred_i, resolve_tgt_i, resolve_br_i,
           resolve_taken_i, resolve_br_metadata_fwd_i, exc_v_i, exc_pc_i, attaboy_yumi_i,
    output resolve_ready_o, redirect_v_o, redirect_pc_o, redirect_br_v_o,
           redirect_br_metadata_fwd_o, redirect_br_taken_o, redirect_br_ntaken_o,
           redirect_br_nonbr_o, attaboy_v_o, attaboy_pc_o, attaboy_br_metadata_fwd_o,
           attaboy_taken_o, attaboy_ntaken_o
  );

  modport master (
    output resolve_v_i, resolve_pc_i, resolve_npc_pred_i, resolve_tgt_i, resolve_br_i,
           resolve_taken_i, resolve_br_metadata_fwd_i, exc_v_i, exc_pc_i, attaboy_yumi_i,
    input  resolve_ready_o, redirect_v_o, redirect_pc_o, redirect_br_v_o,
           redirect_br_metadata_fwd_o, redirect_br_taken_o, redirect_br_ntaken_o,
           redirect_br_nonbr_o, attaboy_v_o, attaboy_pc_o, attaboy_br_metadata_fwd_o,
           attaboy_taken_o, attaboy_ntaken_o
  );
endinterface

// File: rtl/bp_be_fe_feedback.sv
// bp_be_fe_feedback: turns resolved instructions and exceptions into FE redirects, drops
// wrong-path resolves while squashing, and queues correct branch predictions as attaboys.
// Optional feature: define BP_BE_FE_FEEDBACK_ATTABOY_EN to build the attaboy FIFO; without
// it the attaboy outputs are tied to zero.
module bp_be_fe_feedback #(
  parameter bp_params_e  bp_params_p   = e_bp_default_cfg,
  parameter int unsigned attaboy_els_p = 4
) (
  input logic                clk_i,
  input logic                reset_i,
  bp_be_fe_feedback_if.slave fb
);
  localparam int unsigned vaddr_width_lp = (bp_params_p == e_bp_default_cfg) ? 39 : 32;
  localparam int unsigned meta_width_lp  = (bp_params_p == e_bp_default_cfg) ? 36 : 16;

  typedef enum logic [0:0] {
    e_run    = 1'b0,
    e_squash = 1'b1
  } state_e;

  state_e                    r_state, w_state_d;
  logic [vaddr_width_lp-1:0] r_squash_pc, w_squash_pc_d;

  logic                      r_redir_v, w_redir_v_d;
  logic [vaddr_width_lp-1:0] r_redir_pc, w_redir_pc_d;
  logic                      r_redir_br_v, w_redir_br_v_d;
  logic [meta_width_lp-1:0]  r_redir_meta, w_redir_meta_d;
  logic                      r_redir_taken, w_redir_taken_d;
  logic                      r_redir_ntaken, w_redir_ntaken_d;
  logic                      r_redir_nonbr, w_redir_nonbr_d;

  logic w_ready;
  logic w_accept;
  logic w_mispredict;
  logic w_process;
  logic w_enq;

  assign w_accept     = fb.resolve_v_i & w_ready;
  assign w_mispredict = (fb.resolve_npc_pred_i != fb.resolve_tgt_i);
  assign fb.resolve_ready_o = w_ready;

  // Decide whether an accepted resolve is on the correct path
  always_comb begin
    w_process = 1'b0;
    unique case (r_state)
      e_run:    w_process = w_accept;
      e_squash: w_process = w_accept & (fb.resolve_pc_i == r_squash_pc);
      default:  w_process = 1'b0;
    endcase
  end

  // Next state, redirect generation and attaboy enqueue request
  always_comb begin
    w_state_d        = r_state;
    w_squash_pc_d    = r_squash_pc;
    w_redir_v_d      = 1'b0;
    w_redir_pc_d     = '0;
    w_redir_br_v_d   = 1'b0;
    w_redir_meta_d   = '0;
    w_redir_taken_d  = 1'b0;
    w_redir_ntaken_d = 1'b0;
    w_redir_nonbr_d  = 1'b0;
    w_enq            = 1'b0;
    if (fb.exc_v_i) begin
      // Exceptions win over any resolve; ready is already low this cycle
      w_redir_v_d   = 1'b1;
      w_redir_pc_d  = fb.exc_pc_i;
      w_state_d     = e_squash;
      w_squash_pc_d = fb.exc_pc_i;
    end else if (w_process) begin
      if (w_mispredict) begin
        w_redir_v_d      = 1'b1;
        w_redir_pc_d     = fb.resolve_tgt_i;
        w_redir_br_v_d   = 1'b1;
        w_redir_meta_d   = fb.resolve_br_metadata_fwd_i;
        w_redir_taken_d  = fb.resolve_br_i & fb.resolve_taken_i;
        w_redir_ntaken_d = fb.resolve_br_i & ~fb.resolve_taken_i;
        w_redir_nonbr_d  = ~fb.resolve_br_i;
        w_state_d        = e_squash;
        w_squash_pc_d    = fb.resolve_tgt_i;
      end else begin
        w_state_d = e_run;
        w_enq     = fb.resolve_br_i;
      end
    end
  end

  // State and registered redirect outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state        <= e_run;
      r_squash_pc    <= '0;
      r_redir_v      <= 1'b0;
      r_redir_pc     <= '0;
      r_redir_br_v   <= 1'b0;
      r_redir_meta   <= '0;
      r_redir_taken  <= 1'b0;
      r_redir_ntaken <= 1'b0;
      r_redir_nonbr  <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_squash_pc    <= w_squash_pc_d;
      r_redir_v      <= w_redir_v_d;
      r_redir_pc     <= w_redir_pc_d;
      r_redir_br_v   <= w_redir_br_v_d;
      r_redir_meta   <= w_redir_meta_d;
      r_redir_taken  <= w_redir_taken_d;
      r_redir_ntaken <= w_redir_ntaken_d;
      r_redir_nonbr  <= w_redir_nonbr_d;
    end
  end

  assign fb.redirect_v_o               = r_redir_v;
  assign fb.redirect_pc_o              = r_redir_pc;
  assign fb.redirect_br_v_o            = r_redir_br_v;
  assign fb.redirect_br_metadata_fwd_o = r_redir_meta;
  assign fb.redirect_br_taken_o        = r_redir_taken;
  assign fb.redirect_br_ntaken_o       = r_redir_ntaken;
  assign fb.redirect_br_nonbr_o        = r_redir_nonbr;

`ifdef BP_BE_FE_FEEDBACK_ATTABOY_EN
  localparam int unsigned PtrW = (attaboy_els_p > 1) ? $clog2(attaboy_els_p) : 1;
  localparam int unsigned CntW = $clog2(attaboy_els_p + 1);

  logic [vaddr_width_lp-1:0] r_mem_pc    [attaboy_els_p];
  logic [meta_width_lp-1:0]  r_mem_meta  [attaboy_els_p];
  logic                      r_mem_taken [attaboy_els_p];
  logic [PtrW-1:0]           r_rptr, r_wptr;
  logic [CntW-1:0]           r_cnt;

  logic w_full, w_empty, w_push, w_pop;

  assign w_full  = (r_cnt == CntW'(attaboy_els_p));
  assign w_empty = (r_cnt == '0);
  assign w_push  = w_enq & ~w_full;
  assign w_pop   = fb.attaboy_yumi_i & ~w_empty;
  assign w_ready = ~reset_i & ~fb.exc_v_i & ~w_full;

  // Pointers and occupancy; an exception flushes everything including a same-cycle pop
  always_ff @(posedge clk_i) begin
    if (reset_i || fb.exc_v_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + CntW'(1);
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - CntW'(1);
      end
    end
  end

  // Entry storage; contents are only visible through a nonempty head
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_pc[r_wptr]    <= fb.resolve_pc_i;
      r_mem_meta[r_wptr]  <= fb.resolve_br_metadata_fwd_i;
      r_mem_taken[r_wptr] <= fb.resolve_taken_i;
    end
  end

  assign fb.attaboy_v_o               = ~w_empty;
  assign fb.attaboy_pc_o              = w_empty ? '0 : r_mem_pc[r_rptr];
  assign fb.attaboy_br_metadata_fwd_o = w_empty ? '0 : r_mem_meta[r_rptr];
  assign fb.attaboy_taken_o           = ~w_empty & r_mem_taken[r_rptr];
  assign fb.attaboy_ntaken_o          = ~w_empty & ~r_mem_taken[r_rptr];

`ifndef SYNTHESIS
  a_yumi_nonempty: assert property (@(posedge clk_i) disable iff (reset_i)
      fb.attaboy_yumi_i |-> !w_empty)
    else $error("attaboy_yumi_i asserted while the attaboy FIFO is empty");
`endif
`else
  assign w_ready = ~reset_i & ~fb.exc_v_i;

  assign fb.attaboy_v_o               = 1'b0;
  assign fb.attaboy_pc_o              = '0;
  assign fb.attaboy_br_metadata_fwd_o = '0;
  assign fb.attaboy_taken_o           = 1'b0;
  assign fb.attaboy_ntaken_o          = 1'b0;

  logic w_unused;
  assign w_unused = ^{fb.attaboy_yumi_i, w_enq, attaboy_els_p[0]};
`endif

endmodule

// File: tb/tb_bp_be_fe_feedback.sv
// tb_bp_be_fe_feedback: scoreboard bench for bp_be_fe_feedback. A reference model predicts
// ready, redirect and attaboy head per cycle; define BP_BE_FE_FEEDBACK_ATTABOY_EN to match
// a build with the attaboy FIFO.
module tb_bp_be_fe_feedback;
  localparam int unsigned VW  = 39;
  localparam int unsigned MW  = 36;
  localparam int          ELS = 4;
`ifdef BP_BE_FE_FEEDBACK_ATTABOY_EN
  localparam bit ATT = 1'b1;
`else
  localparam bit ATT = 1'b0;
`endif

  typedef logic [VW-1:0] va_t;
  typedef logic [MW-1:0] md_t;
  typedef struct packed {
    logic v;
    va_t  pc;
    logic br_v;
    md_t  meta;
    logic tk;
    logic ntk;
    logic nonbr;
  } redir_t;
  typedef struct packed {
    va_t  pc;
    md_t  meta;
    logic tk;
  } att_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bp_be_fe_feedback_if #(.bp_params_p(e_bp_default_cfg)) fb ();

  bp_be_fe_feedback #(
    .bp_params_p  (e_bp_default_cfg),
    .attaboy_els_p(ELS)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .fb     (fb)
  );

  redir_t rq[$];
  att_t   m_q[$];
  bit     m_sq;
  va_t    m_spc;
  int     n_vec;
  int     n_err;

  // One clock of stimulus: check head and ready before the edge, redirect after it
  task automatic step(input bit rst, input bit v, input va_t pc, input va_t npc,
                      input va_t tgt, input bit br, input bit tk, input md_t meta,
                      input bit exc, input va_t epc, input bit yumi_req);
    redir_t e;
    redir_t got;
    att_t   h;
    bit     y;
    bit     rdy;
    bit     acc;
    logic [VW+MW+2:0] ag;
    logic [VW+MW+2:0] ae;
    @(negedge clk);
    y = yumi_req && (m_q.size() != 0);
    reset                        = rst;
    fb.resolve_v_i               = v;
    fb.resolve_pc_i              = pc;
    fb.resolve_npc_pred_i        = npc;
    fb.resolve_tgt_i             = tgt;
    fb.resolve_br_i              = br;
    fb.resolve_taken_i           = tk;
    fb.resolve_br_metadata_fwd_i = meta;
    fb.exc_v_i                   = exc;
    fb.exc_pc_i                  = epc;
    fb.attaboy_yumi_i            = y;
    #1;
    ag = {fb.attaboy_v_o, fb.attaboy_pc_o, fb.attaboy_br_metadata_fwd_o,
          fb.attaboy_taken_o, fb.attaboy_ntaken_o};
    if (m_q.size() != 0) begin
      h  = m_q[0];
      ae = {1'b1, h.pc, h.meta, h.tk, ~h.tk};
    end else begin
      ae = '0;
    end
    n_vec++;
    if (ag !== ae) begin
      n_err++;
      $display("FAIL attaboy_head: got %h want %h", ag, ae);
    end
    rdy = !rst && !exc && (!ATT || (m_q.size() < ELS));
    n_vec++;
    if (fb.resolve_ready_o !== rdy) begin
      n_err++;
      $display("FAIL resolve_ready: got %b want %b", fb.resolve_ready_o, rdy);
    end
    acc = v && rdy;
    e   = '0;
    if (rst) begin
      m_sq = 1'b0;
      m_q.delete();
    end else if (exc) begin
      e.v   = 1'b1;
      e.pc  = epc;
      m_sq  = 1'b1;
      m_spc = epc;
      m_q.delete();
    end else begin
      if (y) void'(m_q.pop_front());
      if (acc && (!m_sq || pc == m_spc)) begin
        if (npc != tgt) begin
          e.v     = 1'b1;
          e.pc    = tgt;
          e.br_v  = 1'b1;
          e.meta  = meta;
          e.tk    = br & tk;
          e.ntk   = br & ~tk;
          e.nonbr = ~br;
          m_sq    = 1'b1;
          m_spc   = tgt;
        end else begin
          m_sq = 1'b0;
          if (br && ATT) m_q.push_back('{pc: pc, meta: meta, tk: tk});
        end
      end
    end
    rq.push_back(e);
    @(posedge clk);
    #1;
    got = {fb.redirect_v_o, fb.redirect_pc_o, fb.redirect_br_v_o,
           fb.redirect_br_metadata_fwd_o, fb.redirect_br_taken_o,
           fb.redirect_br_ntaken_o, fb.redirect_br_nonbr_o};
    e = rq.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL redirect: got %h want %h", got, e);
    end
  endtask

  task automatic idle(input bit yumi);
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0, yumi);
  endtask

  task automatic res(input va_t pc, input va_t npc, input va_t tgt, input bit br,
                     input bit tk, input md_t meta, input bit yumi);
    step(1'b0, 1'b1, pc, npc, tgt, br, tk, meta, 1'b0, '0, yumi);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * ELS; i++) begin
      if (m_q.size() != 0) idle(1'b1);
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 'h1000, 'h1040, 'h1040, 1'b1, 1'b1, 'h5, 1'b0, '0, 1'b0);
    idle(1'b0);
  endtask

  task automatic test_correct_branch();
    res('h1000, 'h1040, 'h1040, 1'b1, 1'b1, 'h1a, 1'b0);
    res('h1040, 'h1044, 'h1044, 1'b1, 1'b0, 'h1b, 1'b0);
    res('h1044, 'h1048, 'h1048, 1'b0, 1'b0, 'h1c, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
  endtask

  task automatic test_mispredict();
    res('h2000, 'h2004, 'h2100, 1'b1, 1'b1, 'h2b, 1'b0);
    res('h2004, 'h2008, 'h2008, 1'b1, 1'b1, 'h2c, 1'b0);
    res('h2100, 'h2104, 'h2104, 1'b1, 1'b0, 'h2d, 1'b0);
    idle(1'b0);
    drain();
  endtask

  task automatic test_nonbr();
    res('h3000, 'h3080, 'h3004, 1'b0, 1'b0, 'h3a, 1'b0);
    res('h3004, 'h3100, 'h3200, 1'b1, 1'b0, 'h3b, 1'b0);
    res('h3100, 'h3104, 'h3104, 1'b1, 1'b1, 'h3c, 1'b0);
    res('h3200, 'h3204, 'h3204, 1'b0, 1'b0, 'h3d, 1'b0);
    idle(1'b0);
  endtask

  task automatic test_fill();
    drain();
    for (int i = 0; i < 4; i++) begin
      res(va_t'('h4000 + 16 * i), va_t'('h4004 + 16 * i), va_t'('h4004 + 16 * i),
          1'b1, i[0], md_t'(i + 'h40), 1'b0);
    end
    res('h4100, 'h4104, 'h4104, 1'b1, 1'b1, 'h45, 1'b0);
    idle(1'b1);
    res('h4200, 'h4204, 'h4204, 1'b1, 1'b1, 'h46, 1'b1);
    res('h4300, 'h4304, 'h4304, 1'b1, 1'b0, 'h47, 1'b0);
    idle(1'b0);
    drain();
  endtask

  task automatic test_exception();
    drain();
    res('h6000, 'h6010, 'h6010, 1'b1, 1'b1, 'h60, 1'b0);
    res('h6010, 'h6020, 'h6020, 1'b1, 1'b0, 'h61, 1'b0);
    step(1'b0, 1'b1, 'h6020, 'h6024, 'h6024, 1'b1, 1'b1, 'h62, 1'b1, 'h8000_0000, 1'b1);
    idle(1'b0);
    res('h6024, 'h6028, 'h6028, 1'b1, 1'b1, 'h63, 1'b0);
    res('h8000_0000, 'h8000_0004, 'h8000_0004, 1'b1, 1'b1, 'h64, 1'b0);
    idle(1'b0);
    drain();
  endtask

  task automatic test_reset_squash();
    drain();
    for (int i = 0; i < 3; i++) begin
      res(va_t'('h5000 + 8 * i), va_t'('h5004 + 8 * i), va_t'('h5004 + 8 * i),
          1'b1, 1'b1, md_t'(i + 'h50), 1'b0);
    end
    res('h5040, 'h5044, 'h5800, 1'b1, 1'b1, 'h53, 1'b0);
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    idle(1'b0);
    res('h5044, 'h5048, 'h5100, 1'b1, 1'b1, 'h54, 1'b0);
    idle(1'b0);
  endtask

  task automatic test_back_to_back();
    va_t pcs[4] = '{'h100, 'h104, 'h200, 'h204};
    va_t pc;
    va_t tgt;
    va_t npc;
    for (int i = 0; i < 60; i++) begin
      pc  = pcs[$urandom_range(0, 3)];
      tgt = pcs[$urandom_range(0, 3)];
      npc = ($urandom_range(0, 2) == 0) ? pcs[$urandom_range(0, 3)] : tgt;
      step(1'b0, ($urandom_range(0, 3) != 0), pc, npc, tgt, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), md_t'($urandom), ($urandom_range(0, 15) == 0),
           pcs[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
    end
    drain();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_sq  = 1'b0;
    m_spc = '0;
    reset                        = 1'b1;
    fb.resolve_v_i               = 1'b0;
    fb.resolve_pc_i              = '0;
    fb.resolve_npc_pred_i        = '0;
    fb.resolve_tgt_i             = '0;
    fb.resolve_br_i              = 1'b0;
    fb.resolve_taken_i           = 1'b0;
    fb.resolve_br_metadata_fwd_i = '0;
    fb.exc_v_i                   = 1'b0;
    fb.exc_pc_i                  = '0;
    fb.attaboy_yumi_i            = 1'b0;
    test_reset();
    test_correct_branch();
    test_mispredict();
    test_nonbr();
    test_fill();
    test_exception();
    test_reset_squash();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
